// File: rtl/funmin_sweep_ctrl.sv
// Self-check sequencer for the minimised combinational function block.
// Sweeps every minterm, samples the block output and grades it against an expected truth table.
module funmin_sweep_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2**N-1:0]   exp_tt,
  output logic [N-1:0]      inp,
  input  logic              out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N-1:0]   truth_tt,
  output logic [N:0]        err_cnt,
  output logic [N-1:0]      first_err
);

  localparam int              M           = 2**N;
  localparam logic [N-1:0]    LAST_MT     = N'(M - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N:0]      CNT_ONE     = (N+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e            state_q;
  logic [N-1:0]      inp_q;
  logic [3:0]        settle_q;
  logic [M-1:0]      exp_q;
  logic [M-1:0]      truth_q;
  logic [N:0]        err_cnt_q;
  logic [N-1:0]      first_err_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  // Sweep FSM with all result and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inp_q       <= '0;
      settle_q    <= 4'd0;
      exp_q       <= '0;
      truth_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q       <= exp_tt;
            truth_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            inp_q       <= '0;
            settle_q    <= 4'd0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end else begin
            state_q <= IDLE;
          end
        end
        DRIVE: begin
          settle_q <= settle_q + 4'd1;
          if (settle_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            state_q <= DRIVE;
          end
        end
        SAMPLE: begin
          truth_q[inp_q] <= out;
          if (out != exp_q[inp_q]) begin
            err_cnt_q <= err_cnt_q + CNT_ONE;
            if (err_cnt_q == '0) begin
              first_err_q <= inp_q;
            end else begin
              first_err_q <= first_err_q;
            end
          end else begin
            err_cnt_q <= err_cnt_q;
          end
          // The last minterm leaves inp at its value so it never wraps mid-sweep.
          if (inp_q == LAST_MT) begin
            state_q <= FINISH;
          end else begin
            inp_q    <= inp_q + N'(1);
            settle_q <= 4'd0;
            state_q  <= DRIVE;
          end
        end
        FINISH: begin
          pass_q  <= (err_cnt_q == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          inp_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          inp_q   <= '0;
        end
      endcase
    end
  end

  assign inp       = inp_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign truth_tt  = truth_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_funmin_sweep_ctrl.sv
// Directed bench for funmin_sweep_ctrl: vector table of sweeps plus hand-written
// sequences for restart-while-busy, mid-sweep reset and back-to-back sweeps at SETTLE=3.
module tb_funmin_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_tt = 16'h0000;
  logic [3:0]  inp;
  logic        out;
  logic        busy, done, pass;
  logic [15:0] truth_tt;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err;
  logic        fmode = 1'b0;

  logic        start3 = 1'b0;
  logic [3:0]  inp3;
  logic        out3;
  logic        busy3, done3, pass3;
  logic [15:0] truth3;
  logic [4:0]  err3;
  logic [3:0]  ferr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Function block models: F = inp[0], or constant 0 when fmode is set.
  assign out  = fmode ? 1'b0 : inp[0];
  assign out3 = inp3[0];

  funmin_sweep_ctrl #(.N(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt), .inp(inp), .out(out),
    .busy(busy), .done(done), .pass(pass), .truth_tt(truth_tt), .err_cnt(err_cnt),
    .first_err(first_err)
  );

  funmin_sweep_ctrl #(.N(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(16'hAAAA), .inp(inp3), .out(out3),
    .busy(busy3), .done(done3), .pass(pass3), .truth_tt(truth3), .err_cnt(err3),
    .first_err(ferr3)
  );

  typedef struct {
    logic [15:0] exp;
    logic        mode;
    logic [15:0] tt;
    logic [4:0]  ec;
    logic [3:0]  fe;
    logic        ps;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_results(input string tag, input logic [15:0] tt, input logic [4:0] ec,
                             input logic [3:0] fe, input logic ps);
    chk({tag, ".truth_tt"}, 32'(truth_tt), 32'(tt));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, ".first_err"}, 32'(first_err), 32'(fe));
    chk({tag, ".pass"}, 32'(pass), 32'(ps));
  endtask

  // Accept a start at the next edge and follow the sweep; lat is edges from accept to done.
  task automatic do_sweep(input logic [15:0] e, input logic m, output int lat, output bit inp_ok);
    int exp_inp;
    @(negedge clk);
    fmode  = m;
    exp_tt = e;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat    = -1;
    inp_ok = 1'b1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = k;
      end else begin
        exp_inp = (k < 32) ? k / 2 : 15;
        if (inp !== 4'(exp_inp)) inp_ok = 1'b0;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  ok;
    int  ndone;
    int  first_done;
    int  d1, d2;
    int  exp_inp;

    vecs[0] = '{16'hAAAA, 1'b0, 16'hAAAA, 5'd0,  4'd0,  1'b1};
    vecs[1] = '{16'hAAAB, 1'b0, 16'hAAAA, 5'd1,  4'd0,  1'b0};
    vecs[2] = '{16'h8421, 1'b1, 16'h0000, 5'd4,  4'd0,  1'b0};
    vecs[3] = '{16'h5555, 1'b0, 16'hAAAA, 5'd16, 4'd0,  1'b0};
    vecs[4] = '{16'hAAA8, 1'b0, 16'hAAAA, 5'd1,  4'd1,  1'b0};
    vecs[5] = '{16'h2AAA, 1'b0, 16'hAAAA, 5'd1,  4'd15, 1'b0};
    vecs[6] = '{16'h0000, 1'b1, 16'h0000, 5'd0,  4'd0,  1'b1};

    #12;
    chk("reset_outputs", {inp, busy, done, pass, truth_tt, err_cnt, first_err},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_sweep(vecs[i].exp, vecs[i].mode, lat, ok);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'd33);
      chk($sformatf("v%0d.inp_seq", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d.busy_at_done", i), 32'(busy), 32'd0);
      chk_results($sformatf("v%0d", i), vecs[i].tt, vecs[i].ec, vecs[i].fe, vecs[i].ps);
      @(posedge clk); #1;
      chk($sformatf("v%0d.done_pulse", i), 32'(done), 32'd0);
      chk_results($sformatf("v%0d.hold", i), vecs[i].tt, vecs[i].ec, vecs[i].fe, vecs[i].ps);
    end

    // Restart request and exp_tt change while the sweep runs are ignored.
    @(negedge clk);
    fmode = 1'b0; exp_tt = 16'hAAAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_done = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k == 12) exp_tt = 16'h0000;
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          chk_results("ignore_start", 16'hAAAA, 5'd0, 4'd0, 1'b1);
        end
      end
    end
    chk("ignore_start.done_count", 32'(ndone), 32'd1);
    chk("ignore_start.latency", 32'(first_done), 32'd33);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    exp_tt = 16'hAAAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
    end
    chk("midreset.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset.outputs", {inp, busy, done, pass, truth_tt, err_cnt, first_err}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midreset.no_done", 32'(ndone), 32'd0);
    do_sweep(16'hAAAA, 1'b0, lat, ok);
    chk("after_reset.latency", 32'(lat), 32'd33);
    chk_results("after_reset", 16'hAAAA, 5'd0, 4'd0, 1'b1);

    // SETTLE=3 instance with start held high: back-to-back sweeps.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; ok = 1'b1;
    for (int k = 0; k <= 300 && d2 < 0; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k <= 64) begin
        exp_inp = (k < 64) ? k / 4 : 15;
        if (inp3 !== 4'(exp_inp)) ok = 1'b0;
      end
      if (done3) begin
        if (d1 < 0) begin
          d1 = k;
          chk("s3.truth_tt", 32'(truth3), 32'hAAAA);
          chk("s3.err_cnt", 32'(err3), 32'd0);
          chk("s3.pass", 32'(pass3), 32'd1);
        end else begin
          d2 = k;
        end
      end
    end
    start3 = 1'b0;
    chk("s3.inp_seq", 32'(ok), 32'd1);
    chk("s3.first_latency", 32'(d1), 32'd65);
    chk("s3.period", 32'(d2 - d1), 32'd66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
